// File: rtl/ps2_ctrl_pkg.sv
// Shared types and constants for the ps2 command sequencer.
package ps2_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_CAP,
      S_TX_WR,
      S_TX_GAP,
      S_TX_POLL,
      S_WAIT_ACK,
      S_DONE
   } state_e;

   localparam logic PS2_REG_DATA   = 1'b0;
   localparam logic PS2_REG_STATUS = 1'b1;

   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_ERR    = 8'hFC;

endpackage

// File: rtl/ps2_ack_timer.sv
// Acknowledge timeout counter: cleared, counts while enabled, saturates at 24 bits.
module ps2_ack_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   localparam logic [23:0] LAST = 24'(TIMEOUT_CYCLES - 1);

   logic [23:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni || clr_i) begin
         cnt_q <= '0;
      end else if (en_i && cnt_q != 24'hFF_FFFF) begin
         cnt_q <= cnt_q + 24'd1;
      end
   end

   assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// Host command sequencer owning the ps2 core CSR port: writes command/argument
// bytes, waits for the device acknowledge with retry, forwards other bytes as scan codes.
module ps2_cmd_ctrl
   import ps2_ctrl_pkg::*;
#(
   parameter logic [3:0]  CSR_ADDR       = 4'h0,
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_byte,
   input  logic        cmd_has_arg,
   input  logic [7:0]  cmd_arg,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [7:0]  rsp_byte,
   output logic        scan_valid,
   output logic [7:0]  scan_byte,
   output logic        busy,
   output logic [13:0] ps2_csr_a,
   output logic        ps2_csr_we,
   output logic [31:0] ps2_csr_di,
   input  logic [31:0] ps2_csr_do,
   input  logic        ps2_irq
);

   state_e      state_q, state_d;
   logic        rx_pend_q, rx_pend_d;
   logic        ret_wait_q, ret_wait_d;
   logic        phase_q, phase_d;
   logic [7:0]  retry_q, retry_d, retry_inc;
   logic [7:0]  cmd_q, cmd_d, arg_q, arg_d;
   logic        has_arg_q, has_arg_d;
   logic        rsp_err_q, rsp_err_d;
   logic [7:0]  rsp_byte_q, rsp_byte_d;
   logic [7:0]  scan_byte_q, scan_byte_d;
   logic        scan_fire, resend;
   logic [7:0]  resend_byte;
   logic        ready_q, rsp_valid_q, scan_valid_q, busy_q, we_q, sel_q;
   logic [7:0]  di_q;
   logic [7:0]  rx_byte;
   logic        rx_req, expired;

   assign rx_byte   = ps2_csr_do[7:0];
   assign rx_req    = rx_pend_q | ps2_irq;
   assign retry_inc = retry_q + 8'd1;
   // A coinciding interrupt wins over a new command.
   assign cmd_ready = ready_q & ~ps2_irq;

   ps2_ack_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
      .clk_i    (sys_clk),
      .rst_ni   (sys_rst_n),
      .clr_i    (state_q == S_TX_POLL),
      .en_i     (state_q == S_WAIT_ACK),
      .expired_o(expired)
   );

   always_comb begin
      state_d     = state_q;
      ret_wait_d  = ret_wait_q;
      phase_d     = phase_q;
      retry_d     = retry_q;
      cmd_d       = cmd_q;
      arg_d       = arg_q;
      has_arg_d   = has_arg_q;
      rsp_err_d   = rsp_err_q;
      rsp_byte_d  = rsp_byte_q;
      scan_byte_d = scan_byte_q;
      scan_fire   = 1'b0;
      resend      = 1'b0;
      resend_byte = PS2_RESEND;
      case (state_q)
         S_IDLE: begin
            if (rx_req) begin
               state_d    = S_RD_ADDR;
               ret_wait_d = 1'b0;
            end else if (cmd_valid && cmd_ready) begin
               cmd_d     = cmd_byte;
               arg_d     = cmd_arg;
               has_arg_d = cmd_has_arg;
               phase_d   = 1'b0;
               retry_d   = '0;
               state_d   = S_TX_WR;
            end
         end
         S_RD_ADDR: state_d = S_RD_CAP;
         S_RD_CAP: begin
            if (!ret_wait_q) begin
               scan_fire   = 1'b1;
               scan_byte_d = rx_byte;
               state_d     = S_IDLE;
            end else begin
               case (rx_byte)
                  PS2_ACK: begin
                     if (!phase_q && has_arg_q) begin
                        phase_d = 1'b1;
                        retry_d = '0;
                        state_d = S_TX_WR;
                     end else begin
                        rsp_err_d  = 1'b0;
                        rsp_byte_d = rx_byte;
                        state_d    = S_DONE;
                     end
                  end
                  PS2_RESEND: resend = 1'b1;
                  PS2_ERR, 8'h00: begin
                     rsp_err_d  = 1'b1;
                     rsp_byte_d = rx_byte;
                     state_d    = S_DONE;
                  end
                  default: begin
                     scan_fire   = 1'b1;
                     scan_byte_d = rx_byte;
                     state_d     = S_WAIT_ACK;
                  end
               endcase
            end
         end
         S_TX_WR:  state_d = S_TX_GAP;
         S_TX_GAP: state_d = S_TX_POLL;
         S_TX_POLL: if (!ps2_csr_do[0]) state_d = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (rx_req) begin
               state_d    = S_RD_ADDR;
               ret_wait_d = 1'b1;
            end else if (expired) begin
               resend      = 1'b1;
               resend_byte = 8'h00;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (resend) begin
         if (retry_inc <= 8'(MAX_RETRY)) begin
            retry_d = retry_inc;
            state_d = S_TX_WR;
         end else begin
            rsp_err_d  = 1'b1;
            rsp_byte_d = resend_byte;
            state_d    = S_DONE;
         end
      end
      // An interrupt landing on the read entry stays pending for a back-to-back read.
      if (state_d == S_RD_ADDR) rx_pend_d = rx_pend_q & ps2_irq;
      else                      rx_pend_d = rx_pend_q | ps2_irq;
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_q      <= S_IDLE;
         rx_pend_q    <= 1'b0;
         ret_wait_q   <= 1'b0;
         phase_q      <= 1'b0;
         retry_q      <= '0;
         cmd_q        <= '0;
         arg_q        <= '0;
         has_arg_q    <= 1'b0;
         rsp_err_q    <= 1'b0;
         rsp_byte_q   <= '0;
         scan_byte_q  <= '0;
         ready_q      <= 1'b0;
         rsp_valid_q  <= 1'b0;
         scan_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         we_q         <= 1'b0;
         sel_q        <= PS2_REG_DATA;
         di_q         <= '0;
      end else begin
         state_q      <= state_d;
         rx_pend_q    <= rx_pend_d;
         ret_wait_q   <= ret_wait_d;
         phase_q      <= phase_d;
         retry_q      <= retry_d;
         cmd_q        <= cmd_d;
         arg_q        <= arg_d;
         has_arg_q    <= has_arg_d;
         rsp_err_q    <= rsp_err_d;
         rsp_byte_q   <= rsp_byte_d;
         scan_byte_q  <= scan_byte_d;
         ready_q      <= (state_d == S_IDLE) && !rx_pend_d;
         rsp_valid_q  <= (state_d == S_DONE);
         scan_valid_q <= scan_fire;
         busy_q       <= (state_d != S_IDLE);
         we_q         <= (state_d == S_TX_WR);
         sel_q        <= (state_d == S_TX_GAP || state_d == S_TX_POLL) ? PS2_REG_STATUS
                                                                       : PS2_REG_DATA;
         if (state_d == S_TX_WR) di_q <= phase_d ? arg_d : cmd_d;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_err    = rsp_err_q;
   assign rsp_byte   = rsp_byte_q;
   assign scan_valid = scan_valid_q;
   assign scan_byte  = scan_byte_q;
   assign busy       = busy_q;
   assign ps2_csr_we = we_q;
   assign ps2_csr_a  = {CSR_ADDR, 9'b0, sel_q};
   assign ps2_csr_di = {24'b0, di_q};

endmodule

// File: tb/tb_ps2_cmd_ctrl.sv
// Directed bench for ps2_cmd_ctrl with a small behavioural model of the ps2 core.
module tb_ps2_cmd_ctrl;

   localparam int TMO = 100;
   localparam logic [8:0] NR = 9'h100;   // no device reply to this write

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_has_arg = 1'b0;
   logic [7:0]  cmd_byte = '0, cmd_arg = '0;
   logic        cmd_ready, rsp_valid, rsp_err, scan_valid, busy, ps2_csr_we;
   logic [7:0]  rsp_byte, scan_byte;
   logic [13:0] ps2_csr_a;
   logic [31:0] ps2_csr_di;
   logic [31:0] ps2_csr_do = '0;
   logic        ps2_irq = 1'b0;

   always #5 sys_clk = ~sys_clk;

   ps2_cmd_ctrl #(.CSR_ADDR(4'h5), .TIMEOUT_CYCLES(TMO), .MAX_RETRY(3)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_byte(cmd_byte),
      .cmd_has_arg(cmd_has_arg), .cmd_arg(cmd_arg),
      .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_byte(rsp_byte),
      .scan_valid(scan_valid), .scan_byte(scan_byte), .busy(busy),
      .ps2_csr_a(ps2_csr_a), .ps2_csr_we(ps2_csr_we), .ps2_csr_di(ps2_csr_di),
      .ps2_csr_do(ps2_csr_do), .ps2_irq(ps2_irq)
   );

   // Core model: busy for 5 cycles after a write, reply 15 cycles after the write.
   logic [8:0] rsp_tab [0:63];
   logic [7:0] wr_log  [0:63];
   int         wr_time [0:63];
   int         wr_cnt = 0, busy_cnt = 0, rsp_cnt = 0, cyc = 0;
   int         inj_req = 0, inj_seen = 0, rsp_seen = 0, scan_seen = 0;
   logic [7:0] rsp_pend_byte = '0, rx_data = '0, inj_byte = '0, last_scan = '0;

   always @(posedge sys_clk) begin
      cyc        <= cyc + 1;
      ps2_irq    <= 1'b0;
      ps2_csr_do <= ps2_csr_a[0] ? {31'b0, busy_cnt != 0} : {24'b0, rx_data};
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (rsp_cnt > 0) rsp_cnt <= rsp_cnt - 1;
      if (rsp_cnt == 1) begin
         ps2_irq <= 1'b1;
         rx_data <= rsp_pend_byte;
      end else if (inj_seen != inj_req) begin
         inj_seen <= inj_req;
         ps2_irq  <= 1'b1;
         rx_data  <= inj_byte;
      end
      if (ps2_csr_we) begin
         wr_log[wr_cnt[5:0]]  <= ps2_csr_di[7:0];
         wr_time[wr_cnt[5:0]] <= cyc;
         wr_cnt   <= wr_cnt + 1;
         busy_cnt <= 5;
         if (!rsp_tab[wr_cnt[5:0]][8]) begin
            rsp_cnt       <= 15;
            rsp_pend_byte <= rsp_tab[wr_cnt[5:0]][7:0];
         end
      end
      if (rsp_valid) rsp_seen <= rsp_seen + 1;
      if (scan_valid) begin
         scan_seen <= scan_seen + 1;
         last_scan <= scan_byte;
      end
   end

   typedef struct packed {
      logic [7:0]      cmd;
      logic            has_arg;
      logic [7:0]      arg;
      logic [0:3][8:0] rsp;
      int              nwr;
      logic [0:3][7:0] wr;
      logic            err;
      logic [7:0]      rbyte;
      int              gap;
   } vec_t;

   vec_t vecs [6];
   int   n_tests = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_cmd(input logic [7:0] c, input logic ha, input logic [7:0] a,
                           output logic ok);
      int n;
      n = 0;
      @(negedge sys_clk);
      cmd_valid = 1'b1; cmd_byte = c; cmd_has_arg = ha; cmd_arg = a;
      while (!cmd_ready && n < 200) begin
         @(negedge sys_clk);
         n++;
      end
      ok = cmd_ready;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int r0, output logic got);
      int n;
      n = 0;
      while (rsp_seen == r0 && n < 3000) begin
         @(negedge sys_clk);
         n++;
      end
      got = (rsp_seen != r0);
   endtask

   initial begin
      logic ok, got;
      int   base, r0, s0;
      for (int i = 0; i < 64; i++) rsp_tab[i] = NR;

      vecs[0] = '{cmd:8'hED, has_arg:1'b1, arg:8'h07, rsp:{9'h0FA, 9'h0FA, NR, NR}, nwr:2,
                  wr:{8'hED, 8'h07, 8'h00, 8'h00}, err:1'b0, rbyte:8'hFA, gap:0};
      vecs[1] = '{cmd:8'hFF, has_arg:1'b0, arg:8'h00, rsp:{9'h0FE, 9'h0FE, 9'h0FE, 9'h0FE}, nwr:4,
                  wr:{8'hFF, 8'hFF, 8'hFF, 8'hFF}, err:1'b1, rbyte:8'hFE, gap:0};
      vecs[2] = '{cmd:8'hF4, has_arg:1'b0, arg:8'h00, rsp:{NR, NR, NR, NR}, nwr:4,
                  wr:{8'hF4, 8'hF4, 8'hF4, 8'hF4}, err:1'b1, rbyte:8'h00, gap:TMO + 8};
      vecs[3] = '{cmd:8'hF3, has_arg:1'b1, arg:8'h0A, rsp:{9'h0FA, 9'h0FC, NR, NR}, nwr:2,
                  wr:{8'hF3, 8'h0A, 8'h00, 8'h00}, err:1'b1, rbyte:8'hFC, gap:0};
      vecs[4] = '{cmd:8'hEE, has_arg:1'b0, arg:8'h00, rsp:{9'h0FE, 9'h0FA, NR, NR}, nwr:2,
                  wr:{8'hEE, 8'hEE, 8'h00, 8'h00}, err:1'b0, rbyte:8'hFA, gap:0};
      vecs[5] = '{cmd:8'hED, has_arg:1'b1, arg:8'h02, rsp:{9'h0FE, 9'h0FA, 9'h000, NR}, nwr:3,
                  wr:{8'hED, 8'hED, 8'h02, 8'h00}, err:1'b1, rbyte:8'h00, gap:0};

      // Reset state
      repeat (3) @(negedge sys_clk);
      check("rst_ready", cmd_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_scan_valid", scan_valid, 0);
      check("rst_we", ps2_csr_we, 0);
      check("rst_di", ps2_csr_di, 0);
      check("rst_addr", ps2_csr_a, 14'h1400);
      check("rst_rsp_byte", rsp_byte, 0);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      check("ready_after_rst", cmd_ready, 1);

      // Idle receive: scan_valid three cycles after the interrupt
      inj_byte = 8'h1C; inj_req++;
      @(negedge sys_clk);
      check("idle_rx_irq", ps2_irq, 1);
      check("idle_rx_ready_c0", cmd_ready, 0);
      @(negedge sys_clk);
      check("idle_rx_ready_c1", cmd_ready, 0);
      check("idle_rx_scan_c1", scan_valid, 0);
      @(negedge sys_clk);
      check("idle_rx_scan_c2", scan_valid, 0);
      check("idle_rx_busy_c2", busy, 1);
      @(negedge sys_clk);
      check("idle_rx_scan_c3", scan_valid, 1);
      check("idle_rx_byte", scan_byte, 8'h1C);
      @(negedge sys_clk);
      check("idle_rx_scan_pulse", scan_valid, 0);
      check("idle_rx_ready_c4", cmd_ready, 1);

      // Table-driven command vectors
      for (int i = 0; i < 6; i++) begin
         base = wr_cnt;
         r0   = rsp_seen;
         for (int k = 0; k < 4; k++) rsp_tab[6'(base + k)] = vecs[i].rsp[k];
         send_cmd(vecs[i].cmd, vecs[i].has_arg, vecs[i].arg, ok);
         check($sformatf("v%0d_accept", i), ok, 1);
         wait_rsp(r0, got);
         check($sformatf("v%0d_rsp_seen", i), got, 1);
         @(negedge sys_clk);
         @(negedge sys_clk);
         check($sformatf("v%0d_rsp_count", i), rsp_seen - r0, 1);
         check($sformatf("v%0d_err", i), rsp_err, vecs[i].err);
         check($sformatf("v%0d_rsp_byte", i), rsp_byte, vecs[i].rbyte);
         check($sformatf("v%0d_idle", i), busy, 0);
         check($sformatf("v%0d_nwr", i), wr_cnt - base, vecs[i].nwr);
         for (int k = 0; k < vecs[i].nwr; k++)
            check($sformatf("v%0d_wr%0d", i, k), wr_log[6'(base + k)], vecs[i].wr[k]);
         if (vecs[i].gap != 0)
            check($sformatf("v%0d_gap", i), wr_time[6'(base + 1)] - wr_time[6'(base)], vecs[i].gap);
      end

      // Scan code arriving while waiting for the acknowledge
      base = wr_cnt; r0 = rsp_seen; s0 = scan_seen;
      rsp_tab[6'(base)] = 9'h0FA;
      send_cmd(8'hF4, 1'b0, 8'h00, ok);
      check("wscan_we", ps2_csr_we, 1);
      repeat (9) @(negedge sys_clk);
      inj_byte = 8'h1C; inj_req++;
      wait_rsp(r0, got);
      check("wscan_rsp_seen", got, 1);
      @(negedge sys_clk);
      check("wscan_scan_count", scan_seen - s0, 1);
      check("wscan_scan_byte", last_scan, 8'h1C);
      check("wscan_err", rsp_err, 0);
      check("wscan_rsp_byte", rsp_byte, 8'hFA);
      check("wscan_nwr", wr_cnt - base, 1);

      // Interrupt coinciding with a command request: receive goes first
      @(negedge sys_clk);
      base = wr_cnt; r0 = rsp_seen; s0 = scan_seen;
      rsp_tab[6'(base)] = 9'h0FA;
      inj_byte = 8'h55; inj_req++;
      @(negedge sys_clk);
      cmd_valid = 1'b1; cmd_byte = 8'hEE; cmd_has_arg = 1'b0;
      check("coin_ready_low", cmd_ready, 0);
      for (int n = 0; n < 50 && !cmd_ready; n++) @(negedge sys_clk);
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      check("coin_scan_first", scan_seen - s0, 1);
      check("coin_scan_byte", last_scan, 8'h55);
      check("coin_no_wr_yet", wr_cnt - base, 0);
      check("coin_we", ps2_csr_we, 1);
      wait_rsp(r0, got);
      check("coin_rsp_seen", got, 1);
      @(negedge sys_clk);
      check("coin_err", rsp_err, 0);

      // Reset while polling transmit-busy
      base = wr_cnt;
      rsp_tab[6'(base)] = 9'h0FA;
      send_cmd(8'hFF, 1'b0, 8'h00, ok);
      check("mrst_accept", ok, 1);
      check("mrst_first_we", ps2_csr_we, 1);
      check("mrst_first_di", ps2_csr_di, 32'hFF);
      repeat (3) @(negedge sys_clk);
      check("mrst_polling_status", ps2_csr_a[0], 1);
      sys_rst_n = 1'b0;
      @(negedge sys_clk);
      check("mrst_busy", busy, 0);
      check("mrst_addr", ps2_csr_a, 14'h1400);
      check("mrst_we", ps2_csr_we, 0);
      check("mrst_ready", cmd_ready, 0);
      sys_rst_n = 1'b1;
      r0 = rsp_seen;
      repeat (40) @(negedge sys_clk);
      check("mrst_no_rsp", rsp_seen - r0, 0);
      base = wr_cnt;
      rsp_tab[6'(base)] = 9'h0FA;
      send_cmd(8'hF4, 1'b0, 8'h00, ok);
      check("mrst_new_accept", ok, 1);
      wait_rsp(r0, got);
      check("mrst_new_rsp", got, 1);
      @(negedge sys_clk);
      check("mrst_new_err", rsp_err, 0);
      check("mrst_new_byte", rsp_byte, 8'hFA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
